// File: rtl/register_file_if.sv
// Control/write-side bundle for the register file.
// The decoder drives addresses and enables, and the result bus feeds busD.
interface register_file_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] regAddrA;
    logic [ADDR_W-1:0] regAddrB;
    logic [ADDR_W-1:0] regAddrD;
    logic              regReA;
    logic              regReB;
    logic              regWeD;
    logic [DATA_W-1:0] busD;

    modport master (
        output regAddrA, regAddrB, regAddrD,
        output regReA, regReB, regWeD,
        output busD
    );

    modport slave (
        input regAddrA, regAddrB, regAddrD,
        input regReA, regReB, regWeD,
        input busD
    );
endinterface

// File: rtl/register_file.sv
// 32 x 16-bit register file, r0 hardwired to zero.
// Two combinational tri-state read ports and one clocked write port.
module register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    register_file_if.slave    rf,
    // Operand buses stay at the boundary so other drivers can share them.
    output tri   [DATA_W-1:0] busA,
    output tri   [DATA_W-1:0] busB
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    always_comb begin
        regs_d = regs_q;
        if (rf.regWeD && (rf.regAddrD != '0)) begin
            regs_d[rf.regAddrD] = rf.busD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // r0 is forced to zero on read, never stored.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (rf.regAddrA != '0) rd_a = regs_q[rf.regAddrA];
        if (rf.regAddrB != '0) rd_b = regs_q[rf.regAddrB];
    end

    assign busA = rf.regReA ? rd_a : {DATA_W{1'bz}};
    assign busB = rf.regReB ? rd_b : {DATA_W{1'bz}};
endmodule

// File: tb/tb_register_file.sv
// Directed-vector bench for register_file.
// Expected values are hand-computed constants.
module tb_register_file;
    logic        clk;
    logic        rst;
    wire  [15:0] busA;
    wire  [15:0] busB;
    logic        drv_a_en;
    logic        drv_b_en;
    logic [15:0] drv_a_val;
    logic [15:0] drv_b_val;
    int          n_vec;
    int          n_bad;

    register_file_if #(.DATA_W(16), .ADDR_W(5)) rf ();

    register_file #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .rf   (rf.slave),
        .busA (busA),
        .busB (busB)
    );

    // Another bus agent that uses the buses while the file releases them.
    assign busA = drv_a_en ? drv_a_val : 16'hzzzz;
    assign busB = drv_b_en ? drv_b_val : 16'hzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        rf.regAddrD = a;
        rf.busD     = d;
        rf.regWeD   = 1'b1;
        @(posedge clk);
        #1;
        rf.regWeD   = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        drv_a_en = 1'b0;
        drv_b_en = 1'b0;
        drv_a_val = '0;
        drv_b_val = '0;
        rst = 1'b1;
        rf.regAddrA = 5'd5;
        rf.regAddrB = 5'd0;
        rf.regAddrD = 5'd0;
        rf.regReA = 1'b1;
        rf.regReB = 1'b1;
        rf.regWeD = 1'b0;
        rf.busD = '0;
        #12;
        chk("rst_a5", busA, 16'h0000);
        rf.regAddrA = 5'd0;
        #1;
        chk("rst_a0", busA, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // write r3, read port B before and after the edge
        @(negedge clk);
        rf.regAddrB = 5'd3;
        rf.regAddrD = 5'd3;
        rf.busD = 16'd313;
        rf.regWeD = 1'b1;
        #1;
        chk("r3_before_edge", busB, 16'h0000);
        @(posedge clk);
        #1;
        rf.regWeD = 1'b0;
        chk("r3_after_edge", busB, 16'd313);

        // r0 protection
        wr(5'd0, 16'd313);
        rf.regAddrA = 5'd0;
        #1;
        chk("r0_write_dropped", busA, 16'h0000);

        // disabled write does not modify r3
        @(negedge clk);
        rf.regAddrD = 5'd3;
        rf.busD = 16'h1111;
        @(posedge clk);
        #1;
        chk("we0_no_change", busB, 16'd313);

        // dual read
        wr(5'd7, 16'hBEEF);
        rf.regAddrA = 5'd3;
        rf.regAddrB = 5'd7;
        #1;
        chk("dual_a3", busA, 16'd313);
        chk("dual_b7", busB, 16'hBEEF);
        rf.regAddrA = 5'd7;
        #1;
        chk("same_a7", busA, 16'hBEEF);
        chk("same_b7", busB, 16'hBEEF);

        // top register
        wr(5'd31, 16'h8001);
        rf.regAddrA = 5'd31;
        #1;
        chk("r31", busA, 16'h8001);
        chk("r7_kept", busB, 16'hBEEF);

        // buses released when read enable is low
        rf.regReA = 1'b0;
        drv_a_val = 16'h5A5A;
        drv_a_en = 1'b1;
        #1;
        chk("rel_a", busA, 16'h5A5A);
        drv_a_en = 1'b0;
        rf.regReB = 1'b0;
        drv_b_val = 16'hA5A5;
        drv_b_en = 1'b1;
        #1;
        chk("rel_b", busB, 16'hA5A5);
        drv_b_en = 1'b0;
        rf.regReA = 1'b1;
        rf.regReB = 1'b1;

        // async reset between edges
        rf.regAddrB = 5'd3;
        #1;
        chk("pre_rst_r3", busB, 16'd313);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_r3", busB, 16'h0000);
        chk("async_rst_r31", busA, 16'h0000);

        // write attempted during reset is lost
        rf.regAddrD = 5'd5;
        rf.busD = 16'h1234;
        rf.regWeD = 1'b1;
        @(posedge clk);
        #1;
        rf.regWeD = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rf.regAddrA = 5'd5;
        #1;
        chk("rst_write_lost", busA, 16'h0000);

        // file still writable after reset
        wr(5'd5, 16'h1234);
        chk("post_rst_write", busA, 16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout: got running, expected done");
        $fatal(1);
    end
endmodule
